// File: rtl/nonce_sequencer_pkg.sv
// Shared definitions for the hash-search control path.
// Holds FSM state codes, default widths, the positions of the two
// hash bytes that are tested, and the bounty hit rule. The result
// comparator uses the same function, so the rule is defined only here.
package nonce_sequencer_pkg;

    localparam int DEF_NONCE_W = 32;
    localparam int DEF_H_W     = 24;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_CHECK = 2'd3;

    // Tested bytes, given as the distance of each byte's MSB below H_W:
    // the high byte is h[H_W-1 -: 8] and the low byte is h[H_W-9 -: 8].
    localparam int BYTE_W      = 8;
    localparam int HI_BYTE_OFS = 1;
    localparam int LO_BYTE_OFS = 9;

    // A hit needs both tested bytes strictly below the target, so a
    // target of 0 can never hit.
    function automatic logic bounty_hit(input logic [7:0] hi_byte,
                                        input logic [7:0] lo_byte,
                                        input logic [7:0] target);
        return (hi_byte < target) && (lo_byte < target);
    endfunction

endpackage

// File: rtl/nonce_range_counter.sv
// Current-nonce register for the search sequencer.
// Ports:
//   clk, reset_L        clock, asynchronous active-low reset
//   load                capture start_val into cur and end_val as the last nonce
//   inc                 advance cur by one (wraps modulo 2^NONCE_W)
//   start_val, end_val  range bounds, sampled on load
//   cur                 nonce currently under test
//   at_end              cur equals the latched last nonce
module nonce_range_counter #(
    parameter int NONCE_W = 32
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               load,
    input  logic               inc,
    input  logic [NONCE_W-1:0] start_val,
    input  logic [NONCE_W-1:0] end_val,
    output logic [NONCE_W-1:0] cur,
    output logic               at_end
);

    logic [NONCE_W-1:0] end_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur   <= '0;
            end_q <= '0;
        end else if (load) begin
            cur   <= start_val;
            end_q <= end_val;
        end else if (inc) begin
            cur <= cur + NONCE_W'(1);
        end
    end

    // Equality rather than a magnitude compare: wrapped ranges
    // (end below start) then terminate correctly.
    assign at_end = (cur == end_q);

endmodule

// File: rtl/nonce_sequencer.sv
// Hash-search sequencer: walks a nonce range, issues one nonce at a time
// to the hash core, checks each result against a byte target, and stops
// on the first hit, range exhaustion, hash-core timeout or abort.
// Ports:
//   clk, reset_L                  clock, asynchronous active-low reset
//   start, abort                  begin a search (IDLE only) / terminate a search
//   nonce_start, nonce_end        inclusive range, latched on accepted start
//   target                        byte threshold, latched on accepted start
//   hash_start, hash_nonce        one-cycle issue to the core, nonce under test
//   hash_done, H                  core result strobe and hash value
//   busy, done                    not idle / end-of-search pulse (not on abort)
//   found, exhausted, timeout     sticky end cause
//   nonce_valido, bounty          nonce and hash of the last hit
//   attempts                      results checked this search, saturating
module nonce_sequencer
    import nonce_sequencer_pkg::*;
#(
    parameter int NONCE_W  = DEF_NONCE_W,
    parameter int H_W      = DEF_H_W,
    parameter int MAX_WAIT = 1024
) (
    input  logic               clk,
    input  logic               reset_L,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [7:0]         target,
    output logic               hash_start,
    output logic [NONCE_W-1:0] hash_nonce,
    input  logic               hash_done,
    input  logic [H_W-1:0]     H,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               exhausted,
    output logic               timeout,
    output logic [NONCE_W-1:0] nonce_valido,
    output logic [H_W-1:0]     bounty,
    output logic [31:0]        attempts
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    state_t             state;
    logic [WC_W-1:0]    wait_cnt;
    logic [H_W-1:0]     h_q;
    logic [7:0]         target_q;
    logic [NONCE_W-1:0] cur;
    logic               at_end;
    logic               accept;
    logic               hit;
    logic               cnt_inc;

    // abort wins over start, so a simultaneous pair leaves us idle.
    assign accept  = (state == ST_IDLE) && start && !abort;
    assign hit     = bounty_hit(h_q[H_W-HI_BYTE_OFS -: BYTE_W],
                                h_q[H_W-LO_BYTE_OFS -: BYTE_W], target_q);
    assign cnt_inc = (state == ST_CHECK) && !abort && !hit && !at_end;

    assign busy       = (state != ST_IDLE);
    // abort squashes an issue pulse in the same cycle.
    assign hash_start = (state == ST_ISSUE) && !abort;
    assign hash_nonce = cur;

    nonce_range_counter #(.NONCE_W(NONCE_W)) u_range (
        .clk       (clk),
        .reset_L   (reset_L),
        .load      (accept),
        .inc       (cnt_inc),
        .start_val (nonce_start),
        .end_val   (nonce_end),
        .cur       (cur),
        .at_end    (at_end)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            h_q          <= '0;
            target_q     <= '0;
            done         <= 1'b0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            timeout      <= 1'b0;
            nonce_valido <= '0;
            bounty       <= '0;
            attempts     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        target_q  <= target;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        timeout   <= 1'b0;
                        attempts  <= '0;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (hash_done) begin
                        // Checked before the limit: a result arriving on the
                        // last allowed cycle is still accepted.
                        h_q   <= H;
                        state <= ST_CHECK;
                    end else if (wait_cnt == WC_W'(MAX_WAIT - 1)) begin
                        // This cycle is the MAX_WAIT-th without a result.
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        if (attempts != '1) attempts <= attempts + 32'd1;
                        if (hit) begin
                            nonce_valido <= cur;
                            bounty       <= h_q;
                            found        <= 1'b1;
                            done         <= 1'b1;
                            state        <= ST_IDLE;
                        end else if (at_end) begin
                            exhausted <= 1'b1;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Testbench for nonce_sequencer: table of complete searches against a
// behavioural hash core, plus hand-written timeout, abort and reset runs.
module tb_nonce_sequencer;

    logic        clk = 1'b0;
    logic        reset_L = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] nonce_start = '0;
    logic [31:0] nonce_end = '0;
    logic [7:0]  target = '0;
    logic        hash_start;
    logic [31:0] hash_nonce;
    logic        hash_done = 1'b0;
    logic [23:0] H = '0;
    logic        busy, done, found, exhausted, timeout;
    logic [31:0] nonce_valido;
    logic [23:0] bounty;
    logic [31:0] attempts;

    int checks = 0;
    int errors = 0;

    // Behavioural hash core settings.
    logic        core_en = 1'b1;
    int          lat = 1;
    logic [31:0] hit_n = '0;
    logic [23:0] hit_h = '0;
    logic [23:0] miss_h = '0;
    logic [31:0] issued[$];
    logic [31:0] rsp_n;

    nonce_sequencer #(.NONCE_W(32), .H_W(24), .MAX_WAIT(8)) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .start        (start),
        .abort        (abort),
        .nonce_start  (nonce_start),
        .nonce_end    (nonce_end),
        .target       (target),
        .hash_start   (hash_start),
        .hash_nonce   (hash_nonce),
        .hash_done    (hash_done),
        .H            (H),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .exhausted    (exhausted),
        .timeout      (timeout),
        .nonce_valido (nonce_valido),
        .bounty       (bounty),
        .attempts     (attempts)
    );

    always #5 clk = ~clk;

    // Hash core: records every issued nonce; answers lat cycles later.
    always begin
        @(negedge clk);
        if (hash_start) begin
            rsp_n = hash_nonce;
            issued.push_back(rsp_n);
            if (core_en) begin
                repeat (lat) @(negedge clk);
                hash_done = 1'b1;
                H = (rsp_n == hit_n) ? hit_h : miss_h;
                @(negedge clk);
                hash_done = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ns, ne;
        logic [7:0]  tgt;
        logic [31:0] hn;
        logic [23:0] hh, mh;
        int          l;
        logic        f, e;
        logic [31:0] nv;
        logic [23:0] b;
        int          att;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int i);
        vec_t v;
        bit   got;
        bit   seq_ok;
        v = vecs[i];
        hit_n = v.hn; hit_h = v.hh; miss_h = v.mh; lat = v.l; core_en = 1'b1;
        issued.delete();
        @(negedge clk);
        nonce_start = v.ns; nonce_end = v.ne; target = v.tgt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d_busy_rise", i), 64'(busy), 64'(1));
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk($sformatf("v%0d_done_seen", i), 64'(got), 64'(1));
        chk($sformatf("v%0d_busy_fall", i), 64'(busy), 64'(0));
        chk($sformatf("v%0d_found", i), 64'(found), 64'(v.f));
        chk($sformatf("v%0d_exhausted", i), 64'(exhausted), 64'(v.e));
        chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'(0));
        chk($sformatf("v%0d_nonce_valido", i), 64'(nonce_valido), 64'(v.nv));
        chk($sformatf("v%0d_bounty", i), 64'(bounty), 64'(v.b));
        chk($sformatf("v%0d_attempts", i), 64'(attempts), 64'(v.att));
        chk($sformatf("v%0d_issue_count", i), 64'(issued.size()), 64'(v.att));
        seq_ok = 1'b1;
        for (int k = 0; k < issued.size(); k++)
            if (issued[k] !== 32'(v.ns + 32'(k))) seq_ok = 1'b0;
        chk($sformatf("v%0d_issue_seq", i), 64'(seq_ok), 64'(1));
        @(negedge clk);
        chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'(0));
    endtask

    initial begin
        int   c0, cnt, nstart;
        bit   got, done_seen;

        //          ns            ne            tgt    hit nonce     hit H       miss H      L  f     e     nv            bounty      att
        vecs[0] = '{32'h10,       32'h13,       8'h80, 32'h12,       24'h402000, 24'hFFFF00, 2, 1'b1, 1'b0, 32'h12,       24'h402000, 3};
        vecs[1] = '{32'hFFFFFFFE, 32'h1,        8'h00, 32'hDEADBEEF, 24'h000000, 24'hFFFF00, 1, 1'b0, 1'b1, 32'h12,       24'h402000, 4};
        vecs[2] = '{32'h5,        32'h5,        8'h50, 32'hDEADBEEF, 24'h000000, 24'h406000, 1, 1'b0, 1'b1, 32'h12,       24'h402000, 1};
        vecs[3] = '{32'h5,        32'h5,        8'h50, 32'h5,        24'h404FFF, 24'hFFFF00, 2, 1'b1, 1'b0, 32'h5,        24'h404FFF, 1};
        vecs[4] = '{32'h100,      32'h101,      8'h01, 32'h101,      24'h000000, 24'hFFFF00, 3, 1'b1, 1'b0, 32'h101,      24'h000000, 2};
        vecs[5] = '{32'h7,        32'h7,        8'h80, 32'h7,        24'h7F7F00, 24'hFFFF00, 8, 1'b1, 1'b0, 32'h7,        24'h7F7F00, 1};
        vecs[6] = '{32'h30,       32'h31,       8'h00, 32'h30,       24'h000000, 24'h000000, 1, 1'b0, 1'b1, 32'h7,        24'h7F7F00, 2};
        vecs[7] = '{32'h9,        32'h9,        8'h40, 32'h9,        24'h403F00, 24'hFFFF00, 2, 1'b0, 1'b1, 32'h7,        24'h7F7F00, 1};

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hash_start", 64'(hash_start), 64'(0));
        chk("rst_outputs", 64'({hash_nonce, done, found, exhausted, timeout}), 64'(0));
        chk("rst_results", 64'({nonce_valido, bounty}), 64'(0));
        chk("rst_attempts", 64'(attempts), 64'(0));
        reset_L = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Timeout: core silent, MAX_WAIT=8 -> done 9 cycles after the ISSUE cycle.
        core_en = 1'b0;
        issued.delete();
        nonce_start = 32'h0; nonce_end = 32'h5; target = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c0 = -1; got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (hash_start && c0 < 0) c0 = c;
            if (done) begin got = 1'b1; cnt = c - c0; end
            if (!got) @(negedge clk);
        end
        chk("to_done_seen", 64'(got), 64'(1));
        chk("to_latency", 64'(cnt), 64'(9));
        chk("to_timeout", 64'(timeout), 64'(1));
        chk("to_found_exh", 64'({found, exhausted}), 64'(0));
        chk("to_attempts", 64'(attempts), 64'(0));
        chk("to_issued", 64'(issued.size()), 64'(1));
        chk("to_nonce_valido", 64'(nonce_valido), 64'(32'h7));
        core_en = 1'b1;
        repeat (2) @(negedge clk);

        // start and abort together in IDLE: stays idle.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 64'(busy), 64'(0));
        @(negedge clk);
        chk("start_abort_no_issue", 64'({busy, hash_start}), 64'(0));

        // Abort in WAIT of the third nonce; its late hash_done is ignored.
        lat = 4; hit_n = 32'hDEADBEEF; miss_h = 24'hFFFF00;
        issued.delete();
        nonce_start = 32'h20; nonce_end = 32'h30; target = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nstart = 0; done_seen = 1'b0;
        for (int c = 0; c < 100 && nstart < 3; c++) begin
            if (hash_start) nstart++;
            if (done) done_seen = 1'b1;
            if (nstart < 3) @(negedge clk);
        end
        chk("ab_third_issue", 64'(nstart), 64'(3));
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle_next", 64'(busy), 64'(0));
        for (int c = 0; c < 8; c++) begin
            if (done || busy) done_seen = 1'b1;
            @(negedge clk);
        end
        chk("ab_no_done_late_ignored", 64'(done_seen), 64'(0));
        chk("ab_flags", 64'({found, exhausted, timeout}), 64'(0));
        chk("ab_attempts", 64'(attempts), 64'(2));
        chk("ab_nonce_valido", 64'(nonce_valido), 64'(32'h7));
        chk("ab_bounty", 64'(bounty), 64'(24'h7F7F00));
        chk("ab_issued", 64'(issued.size()), 64'(3));

        // Asynchronous reset in the middle of WAIT.
        hit_n = 32'h12; hit_h = 24'h402000; lat = 4;
        nonce_start = 32'h10; nonce_end = 32'h13; target = 8'h80; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_outputs", 64'({hash_start, hash_nonce, done, found, exhausted, timeout}), 64'(0));
        chk("arst_results", 64'({nonce_valido, bounty, attempts}), 64'(0));
        @(negedge clk);
        reset_L = 1'b1;
        repeat (10) @(negedge clk);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nonce_sequencer.md
# nonce_sequencer

Control block for the hash-search path. It walks a nonce range, issues one nonce at a time to the hash core, and waits for each result. Each returned hash is checked against the byte target using the same bounty rule as the result comparator. The search stops on the first hit, on range exhaustion, on a hash-core timeout, or on abort; the result is held for the host.

## Interface
Parameters:
- NONCE_W, 32, nonce width
- H_W, 24, hash result width (top two bytes are tested)
- MAX_WAIT, 1024, max cycles to wait for hash_done before timeout

Ports:
- clk  in  1  clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a search; sampled only in IDLE
- abort  in  1  level; terminates the search
- nonce_start  in  NONCE_W  first nonce, latched on accepted start
- nonce_end  in  NONCE_W  last nonce (inclusive), latched on accepted start
- target  in  8  byte threshold, latched on accepted start
- hash_start  out  1  one-cycle pulse: hash_nonce is valid, core begins
- hash_nonce  out  NONCE_W  nonce under test
- hash_done  in  1  one-cycle pulse from core: H valid
- H  in  H_W  hash result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a search ends (not on abort)
- found / exhausted / timeout  out  1 each  sticky end cause; cleared on accepted start
- nonce_valido  out  NONCE_W  nonce that hit
- bounty  out  H_W  H of the hit
- attempts  out  32  hash results checked this search, saturating

## Operation
- States: IDLE, ISSUE, WAIT, CHECK.
- IDLE, start=1, abort=0:
  - latch nonce_start, nonce_end and target
  - cur ← nonce_start
  - clear found, exhausted, timeout and attempts
  - go to ISSUE
- ISSUE:
  - hash_start=1 and hash_nonce=cur for exactly this cycle
  - clear wait counter
  - go to WAIT
- WAIT:
  - On hash_done=1: capture H into h_q, go to CHECK.
  - Otherwise the wait counter increments. When it reaches MAX_WAIT: set timeout, pulse done, go to IDLE.
- CHECK:
  - Increment attempts (saturating).
  - Hit is h_q[H_W-1:H_W-8] < target AND h_q[H_W-9:H_W-16] < target, unsigned strict compare.
  - On hit: nonce_valido ← cur, bounty ← h_q, found=1, done pulse, go to IDLE.
  - Else if cur == nonce_end: exhausted=1, done pulse, go to IDLE.
  - Else cur ← cur+1 (mod 2^NONCE_W), go to ISSUE.
- abort=1 in any non-IDLE state:
  - next state is IDLE
  - no done pulse, no flag set; nonce_valido and bounty keep their prior values
  - a pending ISSUE pulse is suppressed
- Wrap-around: nonce_end < nonce_start searches through all-ones to 0, then up to nonce_end. nonce_start == nonce_end tests exactly one nonce.
- target=0 can never hit; the range runs to exhaustion.
- start while busy is ignored. start and abort together in IDLE: abort wins, stay IDLE.
- hash_done outside WAIT is ignored, including in the ISSUE cycle.

## Timing
- Reset (async assert, synchronous release):
  - state IDLE
  - all outputs 0: hash_start, hash_nonce, busy, done, found, exhausted, timeout, nonce_valido, bounty, attempts
- busy rises the cycle after start is accepted.
- Per nonce: 1 (ISSUE) + L (hash_done arrives L≥1 cycles after hash_start) + 1 (CHECK) = L+2 cycles.
- done, found, exhausted, timeout, nonce_valido and bounty update on the same edge that returns to IDLE; busy falls on that edge.
- Timeout: hash_done absent for MAX_WAIT consecutive WAIT cycles. If hash_done arrives in the cycle the counter reaches MAX_WAIT, hash_done wins.
- Reset mid-search: immediate return to IDLE with all outputs 0.

## Structure
- Shared package:
  - state enum (IDLE, ISSUE, WAIT, CHECK)
  - NONCE_W and H_W defaults
  - byte-field positions of the two tested bytes
  - the hit function (two-byte strict-less compare), shared with the comparator so the rule has one definition
- One sub-module is natural: nonce_range_counter. It holds cur and the latched end, and provides load, increment, and at_end (cur == end).

## Test plan
- Range 0x10..0x13, target 0x80, core returns H=0xFF_FF_00 for nonces 0x10, 0x11 and 0x40_20_00 for 0x12 → found=1, nonce_valido=0x12, bounty=0x402000, attempts=3, nonce 0x13 never issued.
- Range 0xFFFFFFFE..0x00000001, target 0x00 → hash_nonce sequence FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1, attempts=4.
- Hit needs both bytes below target: target 0x50 with H=0x40_60_00 → no hit; with H=0x40_4F_FF → hit.
- MAX_WAIT=8, core never answers → timeout=1 and done pulse 8 cycles after entering WAIT; attempts=0.
- abort asserted in WAIT of the 3rd nonce → IDLE next cycle, no done pulse, flags 0, prior nonce_valido retained. A late hash_done is ignored.
- reset_L pulsed low mid-WAIT, asynchronous to clk → all outputs 0 immediately. A new start afterwards runs a clean search.
